// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: word type, reset/bubble constants,
// the IF/ID register load actions and the sequential-PC helper.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    // Bubble instruction (addi x0,x0,0) and the default reset fetch address.
    localparam word_t RV_NOP_INSTR = 32'h0000_0013;
    localparam word_t RV_RESET_PC  = 32'h0000_0000;

    // What the IF/ID register does on the coming rising edge.
    typedef enum logic [1:0] {
        IFID_HOLD    = 2'd0,
        IFID_BUBBLE  = 2'd1,
        IFID_CAPTURE = 2'd2
    } ifid_action_e;

    // Sequential next PC; wraps modulo 2^32 with no flag.
    function automatic word_t pc_plus_4_of(input word_t pc_in);
        return pc_in + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface if_stage_if;
    import riscv_pkg::*;

    word_t imem_addr;
    logic  imem_req;
    word_t imem_rdata;
    logic  imem_ready;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/if_pc_reg.sv
// Fetch program counter with its next-PC priority selection.
// A redirect from execute beats both the hazard-unit stall and a memory
// stall; otherwise the PC holds on either stall and steps by 4.
module if_pc_reg
    import riscv_pkg::*;
#(
    parameter word_t RESET_PC = RV_RESET_PC
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  stall_f,
    input  logic  pc_src_e,
    input  word_t pc_target_e,
    input  logic  imem_ready,
    output word_t pc_f
);

    word_t pc_d;
    word_t pc_q;

    // Next-PC selection: redirect, then hold on any stall, else sequential.
    always_comb begin
        pc_d = pc_q;
        if (pc_src_e) begin
            pc_d = pc_target_e;
        end else if (stall_f || !imem_ready) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus_4_of(pc_q);
        end
    end

    // PC register; reset wins over every other request.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_f = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC,
// drives the instruction-memory request and holds the IF/ID register.
// Optional build macro IF_PERF_CNT_EN adds fetch_count/bubble_count
// performance counters; without it those ports and registers are absent.
module if_stage
    import riscv_pkg::*;
#(
    parameter word_t RESET_PC  = RV_RESET_PC,
    parameter word_t NOP_INSTR = RV_NOP_INSTR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall_f,
    input  logic       stall_d,
    input  logic       flush_d,
    input  logic       pc_src_e,
    input  word_t      pc_target_e,
    if_stage_if.master imem,
    output word_t      pc_f,
    output word_t      instruction,
    output word_t      pc,
    output word_t      pc_plus_4,
    output logic       valid_d
`ifdef IF_PERF_CNT_EN
    ,
    output word_t      fetch_count,
    output word_t      bubble_count
`endif
);

    ifid_action_e ifid_action;

    word_t ifid_instr_d;
    word_t ifid_instr_q;
    word_t ifid_pc_d;
    word_t ifid_pc_q;
    word_t ifid_pc4_d;
    word_t ifid_pc4_q;
    logic  ifid_valid_d;
    logic  ifid_valid_q;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .stall_f     (stall_f),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_ready  (imem.imem_ready),
        .pc_f        (pc_f)
    );

    assign imem.imem_addr = pc_f;
    assign imem.imem_req  = ~reset;

    // IF/ID action: flush beats stall, a missing memory word becomes a bubble.
    // A redirect without flush still captures; squashing is the hazard unit's call.
    always_comb begin
        ifid_action = IFID_CAPTURE;
        if (flush_d) begin
            ifid_action = IFID_BUBBLE;
        end else if (stall_d) begin
            ifid_action = IFID_HOLD;
        end else if (!imem.imem_ready) begin
            ifid_action = IFID_BUBBLE;
        end
    end

    // IF/ID next values; a bubble keeps the old pc/pc_plus_4 and only clears the payload.
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        case (ifid_action)
            IFID_BUBBLE: begin
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
            IFID_CAPTURE: begin
                ifid_instr_d = imem.imem_rdata;
                ifid_pc_d    = pc_f;
                ifid_pc4_d   = pc_plus_4_of(pc_f);
                ifid_valid_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // IF/ID pipeline register; reset loads a bubble with zeroed pcs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign instruction = ifid_instr_q;
    assign pc          = ifid_pc_q;
    assign pc_plus_4   = ifid_pc4_q;
    assign valid_d     = ifid_valid_q;

`ifdef IF_PERF_CNT_EN
    word_t fetch_cnt_d;
    word_t fetch_cnt_q;
    word_t bubble_cnt_d;
    word_t bubble_cnt_q;

    // Counters follow the IF/ID action, so both hold while decode is stalled.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (ifid_action == IFID_CAPTURE) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (ifid_action == IFID_BUBBLE) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    // Counter registers; wrap silently at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by a
// randomized stream, all compared against a behavioural fetch model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] pc_f;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        valid_d;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    if_stage_if imem_bus ();

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem        (imem_bus.master),
        .pc_f        (pc_f),
        .instruction (instruction),
        .pc          (pc),
        .pc_plus_4   (pc_plus_4),
        .valid_d     (valid_d)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
`endif
    );

    // Reference model state: fetch PC, what decode currently sees, and event tallies.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc_id;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_fetch;
    logic [31:0] m_bubble;
    logic        m_known = 1'b0;

    int checks = 0;
    int errors = 0;

    // Random-phase stimulus holders.
    logic        r_rst;
    logic        r_sf;
    logic        r_sd;
    logic        r_fd;
    logic        r_src;
    logic        r_rdy;
    logic [31:0] r_tgt;

    task automatic check32(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, check the combinational bus, advance the model, cross the edge.
    task automatic applyStimulus(input logic rst, input logic sf, input logic sd, input logic fd,
                                 input logic src, input logic [31:0] tgt,
                                 input logic rdy, input logic [31:0] rdata);
        logic [31:0] fetched_at;
        logic        takes_bubble;
        logic        takes_word;
        reset                = rst;
        stall_f              = sf;
        stall_d              = sd;
        flush_d              = fd;
        pc_src_e             = src;
        pc_target_e          = tgt;
        imem_bus.imem_ready  = rdy;
        imem_bus.imem_rdata  = rdata;
        #1;
        check32("imem_req", {31'b0, imem_bus.imem_req}, {31'b0, ~rst});
        if (m_known) check32("imem_addr", imem_bus.imem_addr, m_pc);
        if (rst) begin
            m_pc     = 32'h0;
            m_instr  = NOP;
            m_pc_id  = 32'h0;
            m_pc4    = 32'h0;
            m_valid  = 1'b0;
            m_fetch  = 32'h0;
            m_bubble = 32'h0;
            m_known  = 1'b1;
        end else begin
            fetched_at   = m_pc;
            m_pc         = src ? tgt : ((sf || !rdy) ? m_pc : m_pc + 32'd4);
            takes_bubble = fd || (!sd && !rdy);
            takes_word   = !fd && !sd && rdy;
            if (takes_bubble) begin
                m_instr  = NOP;
                m_valid  = 1'b0;
                m_bubble = m_bubble + 32'd1;
            end else if (takes_word) begin
                m_instr  = rdata;
                m_pc_id  = fetched_at;
                m_pc4    = fetched_at + 32'd4;
                m_valid  = 1'b1;
                m_fetch  = m_fetch + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Compare every registered output against the model.
    task automatic checkOutput();
        check32("pc_f", pc_f, m_pc);
        check32("instruction", instruction, m_instr);
        check32("ifid_pc", pc, m_pc_id);
        check32("ifid_pc_plus_4", pc_plus_4, m_pc4);
        check32("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
`ifdef IF_PERF_CNT_EN
        check32("fetch_count", fetch_count, m_fetch);
        check32("bubble_count", bubble_count, m_bubble);
`endif
    endtask

    task automatic fetchStep(input logic rdy);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, rdy, $urandom);
        checkOutput();
    endtask

    task automatic redirect(input logic sf, input logic fd, input logic [31:0] tgt);
        applyStimulus(1'b0, sf, 1'b0, fd, 1'b1, tgt, 1'b1, $urandom);
        checkOutput();
    endtask

    initial begin
        // Reset and plain streaming: pc_f 0,4 then a memory stall at 8.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        checkOutput();
        check32("reset_pc_f", pc_f, 32'h0);
        check32("reset_instruction", instruction, NOP);
        fetchStep(1'b1);
        check32("first_valid", {31'b0, valid_d}, 32'h1);
        fetchStep(1'b1);
        check32("stream_pc_f", pc_f, 32'h8);

        // Two memory-stall cycles at 8, then the word at 8 arrives.
        fetchStep(1'b0);
        fetchStep(1'b0);
        check32("memstall_pc_f", pc_f, 32'h8);
        check32("memstall_bubble", instruction, NOP);
        fetchStep(1'b1);
        check32("resume_ifid_pc", pc, 32'h8);
        check32("resume_ifid_pc4", pc_plus_4, 32'hC);

        // Both stalls for three cycles at pc_f=C, then resume.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, $urandom);
            checkOutput();
        end
        check32("frozen_pc_f", pc_f, 32'hC);
        fetchStep(1'b1);
        check32("unfrozen_pc_f", pc_f, 32'h10);

        // Redirect with flush at pc_f=10.
        redirect(1'b0, 1'b1, 32'h40);
        check32("redirect_pc_f", pc_f, 32'h40);
        check32("redirect_valid", {31'b0, valid_d}, 32'h0);
        fetchStep(1'b1);
        check32("target_ifid_pc", pc, 32'h40);

        // Redirect beats stall_f; then the wrap at the top of the address space.
        redirect(1'b1, 1'b0, 32'h100);
        check32("redirect_beats_stall", pc_f, 32'h100);
        redirect(1'b0, 1'b1, 32'hFFFF_FFFC);
        fetchStep(1'b1);
        check32("wrap_pc_f", pc_f, 32'h0);
        check32("wrap_ifid_pc4", pc_plus_4, 32'h0);

        // Mid-stream reset while decode is stalled.
        redirect(1'b0, 1'b1, 32'h24);
        fetchStep(1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        checkOutput();
        check32("midreset_pc_f", pc_f, 32'h0);
        check32("midreset_instruction", instruction, NOP);

        // Randomized mix of stalls, flushes, redirects, memory waits and resets.
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(0, 63) == 0);
            r_src = ($urandom_range(0, 7) == 0);
            r_fd  = r_src ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            r_sf  = ($urandom_range(0, 5) == 0);
            r_sd  = r_sf ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) r_tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            applyStimulus(r_rst, r_sf, r_sd, r_fd, r_src, r_tgt, r_rdy, $urandom);
            checkOutput();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage pipelined RV32I core. It sits directly upstream of the decode stage.
- Owns the program counter and drives the instruction-memory request.
- Applies hazard-unit stall/flush and execute-stage branch/jump redirects.
- Holds the IF/ID pipeline register that feeds decode its instruction, pc and pc_plus_4.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall_f  input  1  hazard unit: hold PC
stall_d  input  1  hazard unit: hold IF/ID register
flush_d  input  1  hazard unit: squash IF/ID register
pc_src_e  input  1  execute: taken branch/jump, redirect PC
pc_target_e  input  32  execute: redirect target address
imem_addr  output  32  instruction-memory address (= pc_f, combinational)
imem_req  output  1  fetch request, 0 while reset asserted
imem_rdata  input  32  instruction word, valid same cycle when imem_ready=1
imem_ready  input  1  memory has returned imem_rdata for imem_addr this cycle
pc_f  output  32  current fetch PC (registered)
instruction  output  32  IF/ID: fetched instruction to decode
pc  output  32  IF/ID: PC of that instruction
pc_plus_4  output  32  IF/ID: pc + 4
valid_d  output  1  IF/ID: 1 = real instruction, 0 = bubble

Behaviour:
- Reset (synchronous, priority over everything):
  - pc_f = RESET_PC.
  - instruction = NOP_INSTR, pc = 0, pc_plus_4 = 0, valid_d = 0.
  - imem_req = 0 during the reset cycle.
- Fetch is single-cycle. imem_addr = pc_f combinationally. The word is consumed in the same cycle if imem_ready=1 and is visible on the IF/ID outputs after the next rising edge, i.e. 1-cycle fetch-to-decode latency.
- Next-PC priority, highest first:
  - reset: RESET_PC
  - pc_src_e=1: pc_target_e (overrides stall_f and imem_ready=0)
  - stall_f=1: hold pc_f
  - imem_ready=0: hold pc_f and retry the same address
  - else: pc_f+4
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- pc_target_e is loaded verbatim; no alignment check (see optional feature).
- IF/ID register priority, highest first:
  - reset: bubble
  - flush_d=1: bubble, i.e. instruction=NOP_INSTR, valid_d=0, pc/pc_plus_4 hold their previous values
  - stall_d=1: hold all four outputs
  - imem_ready=0: bubble
  - else: capture imem_rdata, pc_f, pc_f+4, and set valid_d=1
- Redirect cycle: the hazard unit asserts flush_d together with pc_src_e. The wrong-path word fetched that cycle must never reach decode with valid_d=1.
- If pc_src_e arrives without flush_d, the block still captures the fetched word. Squashing is the hazard unit's job, and is not inferred here.
- stall_f=1 with stall_d=0 is legal; the IF/ID register keeps capturing the re-fetched word at the held PC.
- A memory stall mid-stream (imem_ready low for N cycles) inserts N bubbles. The PC does not advance, and fetch resumes at the same address.

Optional Feature:
Macro IF_PERF_CNT_EN.
- When defined, two extra outputs exist:
  - fetch_count[31:0]: +1 on every cycle IF/ID captures a valid instruction.
  - bubble_count[31:0]: +1 on every cycle IF/ID loads a bubble, whether from flush or imem_ready=0.
- Both counters reset to 0 and wrap silently at 2^32.
- Counters hold during stall_d.
- When the macro is undefined, these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package riscv_pkg: NOP_INSTR constant, RESET_PC default, XLEN=32 constant.
- One natural sub-module, if_pc_reg: PC register plus next-PC priority mux.
- The IF/ID register and perf counters stay in if_stage.

Test Plan:
1. Reset, then 4 cycles with imem_ready=1 → pc_f sequence 0,4,8,C; IF/ID pc lags by one cycle; valid_d=1 from the 2nd cycle.
2. imem_ready=0 for 2 cycles at pc_f=8 → pc_f holds 8; two bubbles (instruction=32'h13, valid_d=0); then the word at 8 is delivered with pc=8, pc_plus_4=C.
3. At pc_f=10, pc_src_e=1, pc_target_e=40, flush_d=1 → next pc_f=40; IF/ID bubble; following cycle IF/ID pc=40.
4. Assert stall_f=1 and stall_d=1 for 3 cycles at pc_f=C → pc_f and all IF/ID outputs frozen; then resume with pc_f=10.
5. Assert pc_src_e=1 and stall_f=1 in the same cycle, pc_target_e=100 → pc_f=100 (redirect wins). Separately, pc_f=FFFF_FFFC advances to 0.
6. Assert reset mid-stream at pc_f=24 with stall_d=1 → next cycle pc_f=0, valid_d=0, instruction=32'h13. With IF_PERF_CNT_EN, both counters read 0.
